// File: rtl/machine_seq_arbiter.sv
// machine_seq_arbiter
// Round-robin scheduler sharing one serial sequence-recognizer machine among
// N_REQ requesters. The granted frame is shifted LSB-first into the machine,
// m_f is sampled one cycle behind each bit, and a hit count (plus an optional
// per-bit trace) is returned with a one-cycle done pulse.
//
// Optional feature macro: MACHINE_SEQ_TRACE_EN
//   defined   -> f_trace register is built and driven
//   undefined -> f_trace is tied to 0 (port list unchanged)
//
// Ports:
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   req        level request per requester
//   req_data   frames, requester i at [i*DATA_W +: DATA_W]
//   req_len    frame lengths, requester i at [i*LEN_W +: LEN_W], clamped to DATA_W
//   grant      one-hot, requester being served (CLR..DONE)
//   done       one-cycle pulse, results valid
//   hit_count  number of sampled m_f = 1 events (saturating)
//   f_trace    bit k = m_f after input bit k
//   busy       high whenever not IDLE
//   m_x        serial input to the shared machine
//   m_rst      reset to the shared machine
//   m_f        output of the shared machine
module machine_seq_arbiter #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ*LEN_W-1:0]    req_len,
    output logic [N_REQ-1:0]          grant,
    output logic                      done,
    output logic [LEN_W-1:0]          hit_count,
    output logic [DATA_W-1:0]         f_trace,
    output logic                      busy,
    output logic                      m_x,
    output logic                      m_rst,
    input  logic                      m_f
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(DATA_W);

    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;

    state_t state_reg, state_next;

    logic [IDX_W-1:0]  last_reg;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  cand;
    logic              win_valid;
    logic              start;
    logic              sample_en;
    logic [DATA_W-1:0] data_reg;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  idx_reg;
    logic [N_REQ-1:0]  grant_reg;
    logic [LEN_W-1:0]  hit_reg;
    logic [DATA_W-1:0] trace_out;

    logic [DATA_W-1:0] data_arr  [N_REQ];
    logic [LEN_W-1:0]  len_clamp [N_REQ];

    // Unpack requester fields and clamp each length to DATA_W.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            assign data_arr[gi]  = req_data[gi*DATA_W +: DATA_W];
            assign len_clamp[gi] = (req_len[gi*LEN_W +: LEN_W] > MAX_LEN) ?
                                   MAX_LEN : req_len[gi*LEN_W +: LEN_W];
        end
    endgenerate

    // Round-robin search starting just after the last winner.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = IDX_W'((int'(last_reg) + off) % N_REQ);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign start = (state_reg == IDLE) && win_valid;

    // m_f reflects the bit registered on the previous edge, so the first
    // SHIFT cycle carries nothing to sample and DRAIN carries the last bit.
    assign sample_en = ((state_reg == SHIFT) && (idx_reg != '0)) ||
                       (state_reg == DRAIN);

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (win_valid) state_next = CLR;
            CLR:     state_next = (len_reg == '0) ? DONE : SHIFT;
            SHIFT:   if (idx_reg == len_reg - 1'b1) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Frame datapath: capture on IDLE->CLR, shift during SHIFT, count hits.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_reg  <= IDX_W'(N_REQ - 1);
            data_reg  <= '0;
            len_reg   <= '0;
            idx_reg   <= '0;
            grant_reg <= '0;
            hit_reg   <= '0;
        end else begin
            if (start) begin
                last_reg  <= win_idx;
                data_reg  <= data_arr[win_idx];
                len_reg   <= len_clamp[win_idx];
                grant_reg <= N_REQ'(1) << win_idx;
                hit_reg   <= '0;
                idx_reg   <= '0;
            end
            if (state_reg == SHIFT) begin
                data_reg <= data_reg >> 1;
                idx_reg  <= idx_reg + 1'b1;
            end
            if (sample_en && m_f && (hit_reg != '1))
                hit_reg <= hit_reg + 1'b1;
            if (state_reg == DONE)
                grant_reg <= '0;
        end
    end

`ifdef MACHINE_SEQ_TRACE_EN
    logic [DATA_W-1:0] trace_reg;
    logic [DATA_W-1:0] mask_reg;

    // mask_reg walks one bit per sample, so it always points at the trace
    // bit belonging to the sample currently presented on m_f.
    always_ff @(posedge clk) begin
        if (rst) begin
            trace_reg <= '0;
            mask_reg  <= '0;
        end else if (start) begin
            trace_reg <= '0;
            mask_reg  <= DATA_W'(1);
        end else if (sample_en) begin
            if (m_f) trace_reg <= trace_reg | mask_reg;
            mask_reg <= mask_reg << 1;
        end
    end

    assign trace_out = trace_reg;
`else
    assign trace_out = '0;
`endif

    // Outputs; all forced to 0 (m_rst to 1) while reset is asserted.
    always_comb begin
        grant     = '0;
        done      = 1'b0;
        busy      = 1'b0;
        m_x       = 1'b0;
        m_rst     = 1'b1;
        hit_count = '0;
        f_trace   = '0;
        if (!rst) begin
            grant     = grant_reg;
            done      = (state_reg == DONE);
            busy      = (state_reg != IDLE);
            m_x       = (state_reg == SHIFT) ? data_reg[0] : 1'b0;
            m_rst     = (state_reg == CLR);
            hit_count = hit_reg;
            f_trace   = trace_out;
        end
    end

endmodule
